player_move_scheduler: RTL and testbench

Sequences player motion on the 32-pixel grid for the VGA playfield.
- Takes the four raw switches (SW1 up, SW2 down, SW3 left, SW4 right) plus game events (freeze, collision hit).
- Arbitrates simultaneous presses by fixed priority and rate-limits moves with a cooldown.
- Runs a death/respawn state machine and owns the registered player position consumed by the renderer and collision logic.

---
 rtl/player_move_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_player_move_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_scheduler.sv
// player_move_scheduler: synchronizes the four direction switches, arbitrates
// them by fixed priority (up > down > left > right), rate-limits moves with a
// cooldown and runs the death/respawn sequence that owns the player position.
// Optional build macro: PLAYER_LIVES_EN (three lives, then GAME_OVER).
module player_move_scheduler #(
    parameter int unsigned H_DISPLAY       = 640,
    parameter int unsigned V_DISPLAY       = 480,
    parameter int unsigned PLAYER_WIDTH    = 32,
    parameter int unsigned PLAYER_HEIGHT   = 32,
    parameter int unsigned STEP            = 32,
    parameter int unsigned COOLDOWN_CYCLES = 2500000,
    parameter int unsigned RESPAWN_CYCLES  = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    input  logic       i_freeze,
    input  logic       i_hit,
    output logic [9:0] o_player_x,
    output logic [9:0] o_player_y,
    output logic       o_move_pulse,
    output logic [1:0] o_dir,
    output logic       o_respawn,
    output logic [1:0] o_state,
    output logic [1:0] o_lives
);

    localparam int unsigned X_RST   = (H_DISPLAY - PLAYER_WIDTH) / 2;
    localparam int unsigned X_MAX   = H_DISPLAY - PLAYER_WIDTH;
    localparam int unsigned Y_RST   = V_DISPLAY - PLAYER_HEIGHT;
    localparam int unsigned CNT_MAX = (COOLDOWN_CYCLES > RESPAWN_CYCLES) ?
                                      COOLDOWN_CYCLES : RESPAWN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COOLDOWN  = 2'd1,
        ST_DEAD      = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic [1:0]         dir_q, dir_d;
    logic               move_q, move_d;
    logic               respawn_q, respawn_d;
    logic [3:0]         sw_s1_q, sw_s2_q;
    logic [3:0]         legal;
    logic [3:0]         cand;
    logic [10:0]        x_ext, y_ext;
`ifdef PLAYER_LIVES_EN
    logic [1:0]         lives_q, lives_d;
`endif

    // Two-flop synchronizer for the raw switches; bit0 up .. bit3 right
    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_s1_q <= 4'b0000;
            sw_s2_q <= 4'b0000;
        end else begin
            sw_s1_q <= {SW4, SW3, SW2, SW1};
            sw_s2_q <= sw_s1_q;
        end
    end

    // Per-direction legality in 11-bit arithmetic so the edge tests never wrap
    always_comb begin
        x_ext    = 11'(x_q);
        y_ext    = 11'(y_q);
        legal[0] = (y_ext >= 11'(STEP));
        legal[1] = ((y_ext + 11'(STEP)) <= 11'(Y_RST));
        legal[2] = (x_ext >= 11'(STEP));
        legal[3] = ((x_ext + 11'(STEP)) <= 11'(X_MAX));
        cand     = sw_s2_q & legal;
    end

    // Next-state, counter, position and strobe logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        move_d    = 1'b0;
        respawn_d = 1'b0;
`ifdef PLAYER_LIVES_EN
        lives_d   = lives_q;
`endif
        if (((state_q == ST_IDLE) || (state_q == ST_COOLDOWN)) && i_hit) begin
            // A hit beats any move that would otherwise be accepted this cycle
            state_d = ST_DEAD;
            cnt_d   = CNT_W'(RESPAWN_CYCLES);
`ifdef PLAYER_LIVES_EN
            lives_d = lives_q - 2'd1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_freeze && (cand != 4'b0000)) begin
                        if (cand[0]) begin
                            y_d   = y_q - 10'(STEP);
                            dir_d = 2'd0;
                        end else if (cand[1]) begin
                            y_d   = y_q + 10'(STEP);
                            dir_d = 2'd1;
                        end else if (cand[2]) begin
                            x_d   = x_q - 10'(STEP);
                            dir_d = 2'd2;
                        end else begin
                            x_d   = x_q + 10'(STEP);
                            dir_d = 2'd3;
                        end
                        move_d  = 1'b1;
                        cnt_d   = CNT_W'(COOLDOWN_CYCLES);
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
`ifdef PLAYER_LIVES_EN
                        if (lives_q == 2'd0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            x_d       = 10'(X_RST);
                            y_d       = 10'(Y_RST);
                            respawn_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
`else
                        x_d       = 10'(X_RST);
                        y_d       = 10'(Y_RST);
                        respawn_d = 1'b1;
                        state_d   = ST_IDLE;
`endif
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset dominates every state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            x_q       <= 10'(X_RST);
            y_q       <= 10'(Y_RST);
            dir_q     <= 2'd0;
            move_q    <= 1'b0;
            respawn_q <= 1'b0;
`ifdef PLAYER_LIVES_EN
            lives_q   <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
            respawn_q <= respawn_d;
`ifdef PLAYER_LIVES_EN
            lives_q   <= lives_d;
`endif
        end
    end

    assign o_player_x   = x_q;
    assign o_player_y   = y_q;
    assign o_move_pulse = move_q;
    assign o_dir        = dir_q;
    assign o_respawn    = respawn_q;
    assign o_state      = state_q;
`ifdef PLAYER_LIVES_EN
    assign o_lives      = lives_q;
`else
    assign o_lives      = 2'd0;
`endif

endmodule

// File: tb/tb_player_move_scheduler.sv
// Directed bench for player_move_scheduler with COOLDOWN_CYCLES=4, RESPAWN_CYCLES=8.
module tb_player_move_scheduler;

    logic       CLK;
    logic       RST;
    logic       SW1, SW2, SW3, SW4;
    logic       i_freeze, i_hit;
    logic [9:0] o_player_x, o_player_y;
    logic       o_move_pulse, o_respawn;
    logic [1:0] o_dir, o_state, o_lives;

    int total = 0;
    int bad   = 0;

`ifdef PLAYER_LIVES_EN
    localparam int LIVES_EN = 1;
`else
    localparam int LIVES_EN = 0;
`endif

    player_move_scheduler #(
        .COOLDOWN_CYCLES(4),
        .RESPAWN_CYCLES (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SW1         (SW1),
        .SW2         (SW2),
        .SW3         (SW3),
        .SW4         (SW4),
        .i_freeze    (i_freeze),
        .i_hit       (i_hit),
        .o_player_x  (o_player_x),
        .o_player_y  (o_player_y),
        .o_move_pulse(o_move_pulse),
        .o_dir       (o_dir),
        .o_respawn   (o_respawn),
        .o_state     (o_state),
        .o_lives     (o_lives)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] sw;      // {right, left, down, up}
        logic       freeze;
        logic       hit;
        int         ex;
        int         ey;
        int         epulse;
        int         edir;
        int         estate;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n active edges, leaving time 1 unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_sw(input logic [3:0] sw);
        SW1 = sw[0];
        SW2 = sw[1];
        SW3 = sw[2];
        SW4 = sw[3];
    endtask

    task automatic do_reset();
        set_sw(4'b0000);
        i_freeze = 1'b0;
        i_hit    = 1'b0;
        RST      = 1'b1;
        step(2);
        RST      = 1'b0;
    endtask

    int np;
    int np_late;
    int exp_p;
    int exp_lives;

    initial begin
        RST = 1'b1;
        set_sw(4'b0000);
        i_freeze = 1'b0;
        i_hit    = 1'b0;

        //              sw       frz   hit   x    y    pulse dir state
        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 304, 416, 1, 0, 1};
        vecs[1]  = '{4'b0101, 1'b0, 1'b0, 304, 416, 1, 0, 1};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 304, 448, 0, 0, 0};
        vecs[3]  = '{4'b1010, 1'b0, 1'b0, 336, 448, 1, 3, 1};
        vecs[4]  = '{4'b0100, 1'b0, 1'b0, 272, 448, 1, 2, 1};
        vecs[5]  = '{4'b1000, 1'b0, 1'b0, 336, 448, 1, 3, 1};
        vecs[6]  = '{4'b0001, 1'b1, 1'b0, 304, 448, 0, 0, 0};
        vecs[7]  = '{4'b0011, 1'b0, 1'b0, 304, 416, 1, 0, 1};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 304, 448, 0, 0, 0};
        vecs[9]  = '{4'b1100, 1'b0, 1'b0, 272, 448, 1, 2, 1};
        vecs[10] = '{4'b0001, 1'b0, 1'b1, 304, 448, 0, 0, 2};

        // Reset state
        do_reset();
        chk("rst_x", int'(o_player_x), 304);
        chk("rst_y", int'(o_player_y), 448);
        chk("rst_state", int'(o_state), 0);
        chk("rst_pulse", int'(o_move_pulse), 0);
        chk("rst_respawn", int'(o_respawn), 0);
        chk("rst_dir", int'(o_dir), 0);
        chk("rst_lives", int'(o_lives), LIVES_EN ? 3 : 0);

        // Single-move vectors from the reset position, checked at the third edge
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_sw(vecs[i].sw);
            i_freeze = vecs[i].freeze;
            i_hit    = vecs[i].hit;
            step(2);
            chk($sformatf("vec%0d_early_pulse", i), int'(o_move_pulse), 0);
            step(1);
            chk($sformatf("vec%0d_x", i), int'(o_player_x), vecs[i].ex);
            chk($sformatf("vec%0d_y", i), int'(o_player_y), vecs[i].ey);
            chk($sformatf("vec%0d_pulse", i), int'(o_move_pulse), vecs[i].epulse);
            chk($sformatf("vec%0d_dir", i), int'(o_dir), vecs[i].edir);
            chk($sformatf("vec%0d_state", i), int'(o_state), vecs[i].estate);
            set_sw(4'b0000);
            i_freeze = 1'b0;
            i_hit    = 1'b0;
        end

        // Held up switch: pulses at edges 2, 7, 12, 17
        do_reset();
        SW1 = 1'b1;
        np  = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            exp_p = (k >= 2 && ((k - 2) % 5) == 0) ? 1 : 0;
            chk($sformatf("hold_up_pulse_e%0d", k), int'(o_move_pulse), exp_p);
            np += exp_p;
            chk($sformatf("hold_up_y_e%0d", k), int'(o_player_y), 448 - 32 * np);
        end
        chk("hold_up_dir", int'(o_dir), 0);
        SW1 = 1'b0;

        // Right edge: 9 moves reach x=592, then right stays illegal
        do_reset();
        SW4 = 1'b1;
        np = 0;
        np_late = 0;
        for (int k = 0; k < 80; k++) begin
            step(1);
            np += int'(o_move_pulse);
            if (k >= 50) np_late += int'(o_move_pulse);
        end
        chk("right_edge_count", np, 9);
        chk("right_edge_late", np_late, 0);
        chk("right_edge_x", int'(o_player_x), 592);
        SW4 = 1'b0;
        step(4);

        // Left edge: 18 moves from 592 reach x=16, then left stays illegal
        SW3 = 1'b1;
        np = 0;
        np_late = 0;
        for (int k = 0; k < 130; k++) begin
            step(1);
            np += int'(o_move_pulse);
            if (k >= 100) np_late += int'(o_move_pulse);
        end
        chk("left_edge_count", np, 18);
        chk("left_edge_late", np_late, 0);
        chk("left_edge_x", int'(o_player_x), 16);
        chk("left_edge_dir", int'(o_dir), 2);
        SW3 = 1'b0;

        // Freeze blocks acceptance until it drops
        do_reset();
        i_freeze = 1'b1;
        SW1 = 1'b1;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            np += int'(o_move_pulse);
        end
        chk("freeze_count", np, 0);
        chk("freeze_state", int'(o_state), 0);
        i_freeze = 1'b0;
        step(1);
        chk("unfreeze_pulse", int'(o_move_pulse), 1);
        chk("unfreeze_y", int'(o_player_y), 416);
        SW1 = 1'b0;

        // Hit during cooldown, with a stray hit mid-DEAD that must be ignored
        do_reset();
        SW1 = 1'b1;
        step(3);
        chk("hitcd_pre_state", int'(o_state), 1);
        i_hit = 1'b1;
        step(1);
        i_hit = 1'b0;
        chk("hitcd_state", int'(o_state), 2);
        np = 0;
        for (int k = 0; k < 7; k++) begin
            i_hit = (k == 2) ? 1'b1 : 1'b0;
            step(1);
            np += int'(o_move_pulse) + int'(o_respawn);
            chk($sformatf("hitcd_dead_e%0d", k), int'(o_state), 2);
        end
        i_hit = 1'b0;
        chk("hitcd_dead_quiet", np, 0);
        step(1);
        chk("hitcd_respawn", int'(o_respawn), 1);
        chk("hitcd_x", int'(o_player_x), 304);
        chk("hitcd_y", int'(o_player_y), 448);
        chk("hitcd_state_idle", int'(o_state), 0);
        SW1 = 1'b0;
        step(1);
        chk("hitcd_respawn_once", int'(o_respawn), 0);

        // Reset mid-DEAD and mid-COOLDOWN
        do_reset();
        SW4 = 1'b1;
        step(3);
        i_hit = 1'b1;
        step(1);
        i_hit = 1'b0;
        SW4 = 1'b0;
        step(3);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("rst_dead_state", int'(o_state), 0);
        chk("rst_dead_x", int'(o_player_x), 304);
        chk("rst_dead_dir", int'(o_dir), 0);
        SW1 = 1'b1;
        step(4);
        chk("rst_cd_pre_state", int'(o_state), 1);
        SW1 = 1'b0;
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        chk("rst_cd_state", int'(o_state), 0);
        chk("rst_cd_y", int'(o_player_y), 448);

        // Repeated deaths: lives count down, third expiry ends the game if enabled
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i_hit = 1'b1;
            step(1);
            i_hit = 1'b0;
            exp_lives = LIVES_EN ? (2 - i) : 0;
            chk($sformatf("life%0d_lives", i), int'(o_lives), exp_lives);
            chk($sformatf("life%0d_dead", i), int'(o_state), 2);
            step(8);
            if (LIVES_EN != 0 && i == 2) begin
                chk("gameover_state", int'(o_state), 3);
                chk("gameover_respawn", int'(o_respawn), 0);
            end else begin
                chk($sformatf("life%0d_respawn", i), int'(o_respawn), 1);
                chk($sformatf("life%0d_state", i), int'(o_state), 0);
            end
        end
        SW1 = 1'b1;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            np += int'(o_move_pulse);
        end
        SW1 = 1'b0;
        chk("after_lives_pulses", np, LIVES_EN ? 0 : 2);
        chk("after_lives_state", int'(o_state), LIVES_EN ? 3 : 1);
        do_reset();
        chk("final_rst_state", int'(o_state), 0);
        chk("final_rst_lives", int'(o_lives), LIVES_EN ? 3 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
